// File: rtl/blink_period_meter.sv
// Measures the clock-cycle interval between transitions of an asynchronous blink line.
// Also reports lock when successive intervals agree, and timeout when the line stops toggling.
module blink_period_meter #(
  parameter int CNT_W = 16,
  parameter int TOL   = 0
) (
  input  logic             clk_in1,
  input  logic             rst_n_in1,
  input  logic             led_in1,
  output logic [CNT_W-1:0] period_out1,
  output logic             valid_out1,
  output logic             locked_out1,
  output logic             timeout_out1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);

  state_t           state_r;
  logic             s1_r;
  logic             s2_r;
  logic             prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic             edge_det_s;
  logic [CNT_W-1:0] diff_s;
  logic             match_s;

  // Transition detect on the synchronized line; both polarities count.
  always_comb begin
    edge_det_s = s2_r ^ prev_r;
  end

  // Unsigned distance between the new interval and the one held on the output.
  always_comb begin
    diff_s = {CNT_W{1'b0}};
    if (cnt_r >= period_out1) begin
      diff_s = cnt_r - period_out1;
    end else begin
      diff_s = period_out1 - cnt_r;
    end
    match_s = (diff_s <= TOL_V);
  end

  // Synchronizer, interval counter and measurement FSM with registered outputs.
  always_ff @(posedge clk_in1 or negedge rst_n_in1) begin
    if (!rst_n_in1) begin
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      prev_r       <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      state_r      <= IDLE;
      period_out1  <= {CNT_W{1'b0}};
      valid_out1   <= 1'b0;
      locked_out1  <= 1'b0;
      timeout_out1 <= 1'b0;
    end else begin
      s1_r       <= led_in1;
      s2_r       <= s1_r;
      prev_r     <= s2_r;
      valid_out1 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (edge_det_s) begin
            cnt_r   <= CNT_ONE;
            state_r <= FIRST;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        FIRST, RUN: begin
          // An edge landing on the saturating count still reports a valid period.
          if (edge_det_s) begin
            cnt_r        <= CNT_ONE;
            period_out1  <= cnt_r;
            valid_out1   <= 1'b1;
            timeout_out1 <= 1'b0;
            if (state_r == RUN) begin
              locked_out1 <= match_s;
            end else begin
              locked_out1 <= 1'b0;
            end
            state_r <= RUN;
          end else if (cnt_r == CNT_MAX) begin
            timeout_out1 <= 1'b1;
            locked_out1  <= 1'b0;
            state_r      <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_period_meter.sv
// Scoreboard bench for blink_period_meter: three instances cover the 16-bit/TOL=0,
// 16-bit/TOL=2 and 8-bit configurations; a monitor per instance pops expectations on valid.
module tb_blink_period_meter;

  typedef struct packed {
    logic [15:0] period;
    logic        locked;
    logic        timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led_a = 1'b0, led_b = 1'b0, led_c = 1'b0;
  logic [15:0] period_a, period_b;
  logic [7:0]  period_c;
  logic valid_a, valid_b, valid_c;
  logic locked_a, locked_b, locked_c;
  logic timeout_a, timeout_b, timeout_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int n_checks = 0;
  int n_fail = 0;
  int run_c = 0;
  int max_run_c = 0;

  always #5 clk = ~clk;

  blink_period_meter #(.CNT_W(16), .TOL(0)) u_a (
    .clk_in1(clk), .rst_n_in1(rst_n), .led_in1(led_a), .period_out1(period_a),
    .valid_out1(valid_a), .locked_out1(locked_a), .timeout_out1(timeout_a));

  blink_period_meter #(.CNT_W(16), .TOL(2)) u_b (
    .clk_in1(clk), .rst_n_in1(rst_n), .led_in1(led_b), .period_out1(period_b),
    .valid_out1(valid_b), .locked_out1(locked_b), .timeout_out1(timeout_b));

  blink_period_meter #(.CNT_W(8), .TOL(0)) u_c (
    .clk_in1(clk), .rst_n_in1(rst_n), .led_in1(led_c), .period_out1(period_c),
    .valid_out1(valid_c), .locked_out1(locked_c), .timeout_out1(timeout_c));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_valid(input string name, input exp_t got, input int qsize, input exp_t exp);
    n_checks++;
    if (qsize == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected_valid: got period=%0d locked=%0b timeout=%0b, expected no valid",
               name, got.period, got.locked, got.timeout);
    end else if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_valid: got period=%0d locked=%0b timeout=%0b, expected period=%0d locked=%0b timeout=%0b",
               name, got.period, got.locked, got.timeout, exp.period, exp.locked, exp.timeout);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int p, input logic l, input logic t);
    exp_t e;
    e.period  = 16'(p);
    e.locked  = l;
    e.timeout = t;
    return e;
  endfunction

  // Monitors: compare every valid strobe against the head of the matching queue.
  always @(negedge clk) begin
    exp_t e;
    int sz;
    if (valid_a) begin
      sz = q_a.size();
      e = (sz > 0) ? q_a.pop_front() : mk(0, 1'b0, 1'b0);
      check_valid("a", {period_a, locked_a, timeout_a}, sz, e);
    end
    if (valid_b) begin
      sz = q_b.size();
      e = (sz > 0) ? q_b.pop_front() : mk(0, 1'b0, 1'b0);
      check_valid("b", {period_b, locked_b, timeout_b}, sz, e);
    end
    if (valid_c) begin
      sz = q_c.size();
      e = (sz > 0) ? q_c.pop_front() : mk(0, 1'b0, 1'b0);
      check_valid("c", {8'h00, period_c, locked_c, timeout_c}, sz, e);
      run_c++;
      if (run_c > max_run_c) max_run_c = run_c;
    end else begin
      run_c = 0;
    end
  end

  initial begin
    step(3);
    check("reset_outputs_a", {period_a, valid_a, locked_a, timeout_a}, 32'h0);
    check("reset_outputs_c", {period_c, valid_c, locked_c, timeout_c}, 32'h0);
    rst_n = 1'b1;
    step(2);

    // 1: steady 1024-cycle toggling, lock from the second reported period
    led_a = ~led_a;
    step(1024); led_a = ~led_a; q_a.push_back(mk(1024, 1'b0, 1'b0));
    step(1024); led_a = ~led_a; q_a.push_back(mk(1024, 1'b1, 1'b0));
    step(1024); led_a = ~led_a; q_a.push_back(mk(1024, 1'b1, 1'b0));
    step(10);

    // 2: tolerance window of 2 cycles
    led_b = ~led_b;
    step(1000); led_b = ~led_b; q_b.push_back(mk(1000, 1'b0, 1'b0));
    step(1002); led_b = ~led_b; q_b.push_back(mk(1002, 1'b1, 1'b0));
    step(1005); led_b = ~led_b; q_b.push_back(mk(1005, 1'b0, 1'b0));
    step(10);

    // 3: timeout after the line goes static, sticky across the re-arming edge
    led_c = ~led_c;
    step(250);
    check("timeout_early_c", {31'h0, timeout_c}, 32'h0);
    step(20);
    check("timeout_set_c", {30'h0, timeout_c, locked_c}, 32'h2);
    led_c = ~led_c;
    step(50);
    check("timeout_sticky_c", {31'h0, timeout_c}, 32'h1);
    step(50); led_c = ~led_c; q_c.push_back(mk(100, 1'b0, 1'b0));
    step(10);
    check("timeout_cleared_c", {31'h0, timeout_c}, 32'h0);

    // 4: edges exactly at the maximum count win over timeout
    step(245); led_c = ~led_c; q_c.push_back(mk(255, 1'b0, 1'b0));
    step(255); led_c = ~led_c; q_c.push_back(mk(255, 1'b1, 1'b0));
    step(10);
    check("no_timeout_at_max_c", {31'h0, timeout_c}, 32'h0);

    // 6: edges one cycle apart after a timeout
    step(300);
    check("timeout_before_burst_c", {31'h0, timeout_c}, 32'h1);
    led_c = ~led_c;
    step(1); led_c = ~led_c; q_c.push_back(mk(1, 1'b0, 1'b0));
    step(1); led_c = ~led_c; q_c.push_back(mk(1, 1'b1, 1'b0));
    step(1); led_c = ~led_c; q_c.push_back(mk(1, 1'b1, 1'b0));
    step(10);

    // 5: asynchronous reset mid-interval, then re-measure from scratch
    step(300);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_a", {period_a, valid_a, locked_a, timeout_a}, 32'h0);
    step(2);
    rst_n = 1'b1;
    step(3);
    led_a = ~led_a;
    step(500); led_a = ~led_a; q_a.push_back(mk(500, 1'b0, 1'b0));
    step(10);

    check("pending_a", q_a.size(), 32'h0);
    check("pending_b", q_b.size(), 32'h0);
    check("pending_c", q_c.size(), 32'h0);
    check("consecutive_valids_c", max_run_c, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
